// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard control for a 5-stage pipeline with a multi-cycle mult/div unit.
// Detects load-use hazards and reads of HI/LO (or new mult/div) while the
// mult/div unit is still working, and turns them into a PC/IF-ID freeze plus
// a NOP bubble into ID/EX. Taken branches flush IF/ID unless a stall is
// active in the same cycle. Also tracks mult/div occupancy and counts stalled
// cycles (saturating).
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   id_rs, id_rt      : source register fields of the instruction in ID
//   id_uses_rt        : ID instruction actually reads rt
//   id_uses_md        : ID instruction reads HI/LO or is a mult/div
//   id_branch_taken   : ID branch/jump redirects the PC
//   ex_mem_read       : EX instruction is a load
//   ex_rt             : load destination register in EX
//   md_start          : mult/div enters EX this cycle
//   md_is_div         : qualifies md_start (1 = divide, 0 = multiply)
//   pc_write          : PC update enable
//   ifid_write        : IF/ID load enable
//   ifid_flush        : clear IF/ID on the next edge
//   idex_bubble       : insert NOP into ID/EX
//   md_busy           : mult/div unit occupied
//   md_done           : one-cycle pulse in the last busy cycle
//   stall_cnt         : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,   // 2..63
  parameter int DIV_LAT  = 33   // 2..63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_uses_md,
  input  logic        id_branch_taken,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // Counter is loaded with LAT-1 so that the cycle holding 1 is the last
  // busy cycle and the unit is back in RUN exactly LAT cycles after start.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 1);

  state_t      state_reg, state_next;
  logic [5:0]  md_cnt_reg, md_cnt_next;
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  logic lu;
  logic mdh;
  logic stall;
  logic md_last;

  // ex_rt == 0 is the hardwired zero register, never a real dependency.
  assign lu = ex_mem_read & (ex_rt != 5'd0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mdh   = (state_reg == MD_BUSY) & id_uses_md;
  assign stall = lu | mdh;

  assign md_last = (state_reg == MD_BUSY) & (md_cnt_reg == 6'd1);

  // Next-state logic for the mult/div tracker and the stall counter.
  always_comb begin
    state_next     = state_reg;
    md_cnt_next    = md_cnt_reg;
    stall_cnt_next = stall_cnt_reg;

    case (state_reg)
      RUN: begin
        // A start is taken even when a load-use stall is active this cycle.
        if (md_start) begin
          state_next  = MD_BUSY;
          md_cnt_next = md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        // New starts are ignored until the current operation completes.
        md_cnt_next = md_cnt_reg - 6'd1;
        if (md_cnt_reg == 6'd1) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next  = RUN;
        md_cnt_next = 6'd0;
      end
    endcase

    if (stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  // Pipeline control outputs; a stall freezes the front end and wins over a
  // branch flush so the stalled instruction in IF/ID is not lost. Reset
  // forces a free-running, non-flushing, idle view.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;

    if (!rst) begin
      md_busy = (state_reg == MD_BUSY);
      md_done = md_last;
      if (stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else begin
        ifid_flush = id_branch_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      md_cnt_reg    <= 6'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      md_cnt_reg    <= md_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (default MULT_LAT=5, DIV_LAT=33).
// Each cycle the expected output vector {pc_write, ifid_write, ifid_flush,
// idex_bubble, md_busy, md_done, stall_cnt} is pushed to a scoreboard queue
// when the stimulus is driven, then popped and compared on the falling edge.
// Cycle numbering in each scenario: cycle c runs from rising edge c to c+1.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_uses_md;
  logic        id_branch_taken;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        md_start;
  logic        md_is_div;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [21:0] sb_q[$];
  logic [21:0] got_v;
  logic [21:0] exp_v;
  logic [21:0] dut_vec;

  assign dut_vec = {pc_write, ifid_write, ifid_flush, idex_bubble,
                    md_busy, md_done, stall_cnt};

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_uses_md      (id_uses_md),
    .id_branch_taken (id_branch_taken),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .md_start        (md_start),
    .md_is_div       (md_is_div),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic r, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic umd, input logic br,
                        input logic ms, input logic mdv);
    rst             = r;
    ex_mem_read     = mr;
    ex_rt           = ert;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = urt;
    id_uses_md      = umd;
    id_branch_taken = br;
    md_start        = ms;
    md_is_div       = mdv;
  endtask

  // Push the expected output vector for the cycle just driven.
  task automatic push_exp(input logic pw, input logic iw, input logic fl,
                          input logic bb, input logic busy, input logic done);
    sb_q.push_back({pw, iw, fl, bb, busy, done, exp_stall});
  endtask

  // Advance through the rising edge and update the expected stall count.
  task automatic tick(input logic stall_e, input logic rst_e);
    @(posedge clk);
    #1;
    if (rst_e)
      exp_stall = 16'd0;
    else if (stall_e && exp_stall != 16'hFFFF)
      exp_stall = exp_stall + 16'd1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 5'd8, 5'd8, 5'd8, 1, 1, 1, 1, 0);
    @(posedge clk); @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      push_exp(1, 1, 0, 0, 0, 0);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL reset cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(0, 1);
    end
  endtask

  task automatic test_load_use();
    logic [4:0] ert_t[4] = '{5'd8, 5'd0, 5'd8, 5'd8};
    logic [4:0] rs_t [4] = '{5'd8, 5'd0, 5'd8, 5'd3};
    logic       mr_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       st_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      set_in(0, mr_t[c], ert_t[c], rs_t[c], 5'd4, 1, 0, 0, 0, 0);
      push_exp(!st_t[c], !st_t[c], 0, st_t[c], 0, 0);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL load_use cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(st_t[c], 0);
    end
  endtask

  task automatic test_rt_gating();
    logic [4:0] rs_t [3] = '{5'd3, 5'd3, 5'd9};
    logic       urt_t[3] = '{1'b0, 1'b1, 1'b0};
    logic       st_t [3] = '{1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1, 5'd9, rs_t[c], 5'd9, urt_t[c], 0, 0, 0, 0);
      push_exp(!st_t[c], !st_t[c], 0, st_t[c], 0, 0);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL rt_gating cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(st_t[c], 0);
    end
  endtask

  // Multiply at cycle 0 (busy 1..4, done 4); a divide start in cycle 2 must
  // be ignored; id_uses_md held over cycles 1..5 stalls only cycles 1..4.
  task automatic test_multiply();
    logic ms, mdv, umd, busy, done, st;
    for (int c = 0; c < 7; c++) begin
      ms   = (c == 0) || (c == 2);
      mdv  = (c == 2);
      umd  = (c >= 1) && (c <= 5);
      busy = (c >= 1) && (c <= 4);
      done = (c == 4);
      st   = busy && umd;
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 1, umd, 0, ms, mdv);
      push_exp(!st, !st, 0, st, busy, done);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL multiply cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(st, 0);
    end
  endtask

  // A multiply start coincident with a load-use stall is still accepted.
  task automatic test_md_with_lu();
    logic busy, st;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_in(0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 1, 0);
      else        set_in(0, 0, 5'd0, 5'd7, 5'd0, 0, 0, 0, 0, 0);
      busy = (c >= 1) && (c <= 4);
      st   = (c == 0);
      push_exp(!st, !st, 0, st, busy, c == 4);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL md_with_lu cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(st, 0);
    end
  endtask

  // Start at 0; start held through the done cycle (ignored) and into the
  // RUN cycle 5 where it launches a second multiply (busy 6..9, done 9).
  task automatic test_back_to_back();
    logic ms, busy, done;
    for (int c = 0; c < 11; c++) begin
      ms   = (c == 0) || (c == 4) || (c == 5);
      busy = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
      done = (c == 4) || (c == 9);
      set_in(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, ms, 0);
      push_exp(1, 1, 0, 0, busy, done);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL back_to_back cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(0, 0);
    end
  endtask

  // Divide at 0, reset in cycle 10: busy gone from 11, no done pulse at the
  // cycle (32) where the divide would have finished, stall count cleared.
  task automatic test_divide_reset();
    logic r, umd, busy, st;
    for (int c = 0; c < 41; c++) begin
      r    = (c == 10);
      umd  = (c >= 1);
      busy = (c >= 1) && (c <= 9);
      st   = busy && umd;
      set_in(r, 0, 5'd0, 5'd1, 5'd2, 0, umd, 0, c == 0, 1);
      if (r) push_exp(1, 1, 0, 0, 0, 0);
      else   push_exp(!st, !st, 0, st, busy, 0);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL divide_reset cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(st, r);
    end
  endtask

  // Branch with load-use: stall wins, no flush; next cycle flush applies.
  task automatic test_flush();
    logic st_t[3] = '{1'b1, 1'b0, 1'b0};
    logic br_t[3] = '{1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      set_in(0, st_t[c], 5'd12, 5'd12, 5'd0, 0, 0, br_t[c], 0, 0);
      push_exp(!st_t[c], !st_t[c], br_t[c] && !st_t[c], st_t[c], 0, 0);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL flush cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(st_t[c], 0);
    end
  endtask

  task automatic test_saturation();
    set_in(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 65540; c++) begin
      push_exp(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      got_v = dut_vec; exp_v = sb_q.pop_front(); n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL saturation cyc=%0d got=%h expected=%h", c, got_v, exp_v);
      end
      tick(1, 0);
    end
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_cnt !== 16'hFFFF) begin
        n_errors++;
        $display("FAIL saturation_hold cyc=%0d got=%h expected=ffff", c, stall_cnt);
      end
      tick(0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rt_gating();
    test_multiply();
    test_md_with_lu();
    test_back_to_back();
    test_divide_reset();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
